// File: rtl/sysarr_pkg.sv
// Shared constants and state type for the systolic-array controller.
// Defaults: 4x4 array, 8-bit buffer addresses.
// LAT is the skew fill plus drain depth between first injection and first result.
package sysarr_pkg;

  localparam int N      = 4;
  localparam int ADDR_W = 8;
  localparam int LAT    = 2 * N - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WLOAD = 2'd1,
    S_FEED  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sysarr_ctrl_skew.sv
// Per-row injection window: row r is fed while r <= c < r + M.
// Purely combinational; the caller registers the result.
// No flow control of its own; stall gating happens in the controller.
module sysarr_skew #(
  parameter int N  = sysarr_pkg::N,
  parameter int CW = sysarr_pkg::ADDR_W + 1
) (
  input  logic [CW-1:0] c_i,
  input  logic [CW-1:0] m_i,
  output logic [N-1:0]  row_en_o
);

  localparam int EW = CW + 1;

  logic [EW-1:0] c_ext;
  logic [EW-1:0] m_ext;

  assign c_ext = {1'b0, c_i};
  assign m_ext = {1'b0, m_i};

  // One window compare per row; extra bit keeps r + M from wrapping.
  always_comb begin
    row_en_o = '0;
    for (int r = 0; r < N; r++) begin
      row_en_o[r] = (c_ext >= EW'(r)) && (c_ext < (EW'(r) + m_ext));
    end
  end

endmodule

// File: rtl/sysarr_ctrl.sv
// Systolic-array job sequencer: weight load, skewed input feed, result drain.
// All outputs registered, one cycle behind the state/counters that produce them.
// stall freezes state and counters in WLOAD/FEED and zeroes the strobes.
module sysarr_ctrl
  import sysarr_pkg::*;
#(
  parameter int N      = sysarr_pkg::N,
  parameter int ADDR_W = sysarr_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              wwrite,
  output logic [ADDR_W-1:0] w_addr,
  output logic              active,
  output logic [ADDR_W-1:0] in_addr,
  output logic [N-1:0]      in_row_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  // Counters carry one spare bit so LAT + M - 1 never wraps at maximum M.
  localparam int          CW     = ADDR_W + 1;
  localparam int          LAT_L  = 2 * N - 1;
  localparam logic [CW-1:0] LAT_C  = CW'(LAT_L);
  localparam logic [CW-1:0] W_LAST = CW'(N - 1);

  state_t            state_q;
  logic [CW-1:0]     w_q;
  logic [CW-1:0]     c_q;
  logic [ADDR_W-1:0] m_q;

  logic              busy_q;
  logic              done_q;
  logic              wwrite_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic              active_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [N-1:0]      row_en_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;

  logic [CW-1:0]     m_ext;
  logic [CW-1:0]     c_last;
  logic [N-1:0]      skew_en;

  assign m_ext  = {1'b0, m_q};
  assign c_last = LAT_C + m_ext - CW'(1);

  sysarr_skew #(
    .N  (N),
    .CW (CW)
  ) u_skew (
    .c_i      (c_q),
    .m_i      (m_ext),
    .row_en_o (skew_en)
  );

  // Job FSM, counters and registered outputs; strobes default low every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      c_q         <= '0;
      m_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wwrite_q    <= 1'b0;
      w_addr_q    <= '0;
      active_q    <= 1'b0;
      in_addr_q   <= '0;
      row_en_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      busy_q      <= (state_q != S_IDLE);
      done_q      <= 1'b0;
      wwrite_q    <= 1'b0;
      active_q    <= 1'b0;
      row_en_q    <= '0;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q     <= num_rows;
            w_q     <= '0;
            c_q     <= '0;
            state_q <= S_WLOAD;
          end
        end
        S_WLOAD: begin
          if (!stall) begin
            wwrite_q <= 1'b1;
            w_addr_q <= w_q[ADDR_W-1:0];
            if (w_q == W_LAST) begin
              w_q     <= '0;
              c_q     <= '0;
              state_q <= (m_q == '0) ? S_DONE : S_FEED;
            end else begin
              w_q <= w_q + CW'(1);
            end
          end
        end
        S_FEED: begin
          if (!stall) begin
            active_q  <= 1'b1;
            in_addr_q <= (c_q < m_ext) ? c_q[ADDR_W-1:0] : (m_q - ADDR_W'(1));
            row_en_q  <= skew_en;
            if (c_q >= LAT_C) begin
              out_valid_q <= 1'b1;
              out_addr_q  <= c_q[ADDR_W-1:0] - ADDR_W'(LAT_L);
            end
            if (c_q == c_last) begin
              c_q     <= '0;
              state_q <= S_DONE;
            end else begin
              c_q <= c_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wwrite    = wwrite_q;
  assign w_addr    = w_addr_q;
  assign active    = active_q;
  assign in_addr   = in_addr_q;
  assign in_row_en = row_en_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_sysarr_ctrl.sv
// Self-checking bench for sysarr_ctrl (N=4, ADDR_W=8).
// Expected per-cycle outputs come from a job-level model built as a queue.
// Inputs driven 1 time unit after each rising edge, outputs sampled there too.
module tb_sysarr_ctrl;
  import sysarr_pkg::*;

  localparam int TN   = 4;
  localparam int AW   = 8;
  localparam int TLAT = 2 * TN - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] num_rows;
  logic          stall;
  logic          busy;
  logic          done;
  logic          wwrite;
  logic [AW-1:0] w_addr;
  logic          active;
  logic [AW-1:0] in_addr;
  logic [TN-1:0] in_row_en;
  logic          out_valid;
  logic [AW-1:0] out_addr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          wwrite;
    logic [AW-1:0] w_addr;
    logic          active;
    logic [AW-1:0] in_addr;
    logic [TN-1:0] row;
    logic          ov;
    logic [AW-1:0] out_addr;
  } obs_t;

  typedef struct {
    logic stl;
    logic stt;
    obs_t o;
  } rec_t;

  rec_t          q[$];
  logic [AW-1:0] mw = '0;
  logic [AW-1:0] mi = '0;
  logic [AW-1:0] mo = '0;

  sysarr_ctrl #(.N(TN), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .num_rows  (num_rows),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .wwrite    (wwrite),
    .w_addr    (w_addr),
    .active    (active),
    .in_addr   (in_addr),
    .in_row_en (in_row_en),
    .out_valid (out_valid),
    .out_addr  (out_addr)
  );

  always #5 clock = ~clock;

  function automatic obs_t sample();
    obs_t s;
    s = {busy, done, wwrite, w_addr, active, in_addr, in_row_en, out_valid, out_addr};
    return s;
  endfunction

  function automatic obs_t held();
    obs_t o;
    o = '0;
    o.w_addr   = mw;
    o.in_addr  = mi;
    o.out_addr = mo;
    return o;
  endfunction

  task automatic push(input logic stl, input obs_t o);
    rec_t r;
    r.stl = stl;
    r.stt = 1'b0;
    r.o   = o;
    q.push_back(r);
  endtask

  task automatic add_stalls(input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      o      = held();
      o.busy = 1'b1;
      push(1'b1, o);
    end
  endtask

  // mode 0: no stall, 1: sl stall cycles before feed step sc, 2: random stalls
  task automatic build(input int m, input int mode, input int sc, input int sl, input bit noise);
    obs_t o;
    q.delete();
    for (int w = 0; w < TN; w++) begin
      if (mode == 2 && $urandom_range(0, 4) == 0) add_stalls($urandom_range(1, 2));
      mw       = AW'(w);
      o        = held();
      o.busy   = 1'b1;
      o.wwrite = 1'b1;
      push(1'b0, o);
    end
    if (m > 0) begin
      for (int c = 0; c < TLAT + m; c++) begin
        if (mode == 1 && c == sc) add_stalls(sl);
        if (mode == 2 && $urandom_range(0, 5) == 0) add_stalls($urandom_range(1, 2));
        mi = (c < m) ? AW'(c) : AW'(m - 1);
        if (c >= TLAT) mo = AW'(c - TLAT);
        o        = held();
        o.busy   = 1'b1;
        o.active = 1'b1;
        o.ov     = (c >= TLAT);
        for (int r = 0; r < TN; r++) o.row[r] = (c >= r) && (c < r + m);
        push(1'b0, o);
      end
    end
    o      = held();
    o.busy = 1'b1;
    o.done = 1'b1;
    push((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, o);
    o = held();
    push((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, o);
    if (noise) begin
      for (int k = 0; k < q.size() - 1; k++) q[k].stt = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic kick(input int m);
    start    = 1'b1;
    num_rows = AW'(m);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_q(input string tag, input int lim, output int de, output int nd);
    obs_t got;
    de = -1;
    nd = 0;
    for (int k = 0; k < lim; k++) begin
      stall    = q[k].stl;
      start    = q[k].stt;
      num_rows = AW'($urandom);
      @(posedge clock);
      #1;
      got = sample();
      total++;
      if (got !== q[k].o) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", tag, k + 1, got, q[k].o);
      end
      if (got.done === 1'b1) begin
        nd++;
        if (de < 0) de = k + 1;
      end
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    start = 1'b1;
    stall = 1'b1;
    num_rows = 8'd5;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    got = sample();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    mw = '0; mi = '0; mo = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    int de, nd;
    build(3, 0, 0, 0, 1'b0);
    kick(3);
    run_q("basic", q.size(), de, nd);
    total++;
    if (de != 15) begin
      bad++;
      $display("FAIL basic_done_cycle got=%0d exp=15", de);
    end
  endtask

  task automatic test_stall();
    int de, nd;
    build(3, 1, 8, 2, 1'b0);
    kick(3);
    run_q("stall", q.size(), de, nd);
    total++;
    if (de != 17) begin
      bad++;
      $display("FAIL stall_done_cycle got=%0d exp=17", de);
    end
  endtask

  task automatic test_m_zero();
    int de, nd;
    build(0, 0, 0, 0, 1'b0);
    kick(0);
    run_q("m_zero", q.size(), de, nd);
    total++;
    if (de != 5) begin
      bad++;
      $display("FAIL m_zero_done_cycle got=%0d exp=5", de);
    end
  endtask

  task automatic test_start_ignored();
    int de, nd;
    build(2, 0, 0, 0, 1'b1);
    kick(2);
    run_q("start_ign", q.size(), de, nd);
    total++;
    if (nd != 1 || de != 14) begin
      bad++;
      $display("FAIL start_ign_done got=%0d@%0d exp=1@14", nd, de);
    end
  endtask

  task automatic test_reset_mid();
    int de, nd;
    obs_t got;
    build(3, 0, 0, 0, 1'b0);
    kick(3);
    run_q("rst_mid_pre", TN + 5, de, nd);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mw = '0; mi = '0; mo = '0;
    got = sample();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL rst_mid_zero got=%h exp=0", got);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      got = sample();
      total++;
      if (got !== obs_t'(0)) begin
        bad++;
        $display("FAIL rst_mid_idle cyc=%0d got=%h exp=0", i, got);
      end
    end
    build(1, 0, 0, 0, 1'b0);
    kick(1);
    run_q("rst_mid_post", q.size(), de, nd);
    total++;
    if (de != 13) begin
      bad++;
      $display("FAIL rst_mid_restart_done got=%0d exp=13", de);
    end
  endtask

  task automatic test_max_rows();
    int de, nd;
    build(255, 0, 0, 0, 1'b0);
    kick(255);
    run_q("max_rows", q.size(), de, nd);
    total++;
    if (de != TN + TLAT + 255 + 1) begin
      bad++;
      $display("FAIL max_rows_done got=%0d exp=%0d", de, TN + TLAT + 256);
    end
  endtask

  task automatic test_random();
    int de, nd, m;
    for (int j = 0; j < 15; j++) begin
      m = $urandom_range(0, 9);
      build(m, 2, 0, 0, 1'($urandom_range(0, 1)));
      kick(m);
      run_q("random", q.size(), de, nd);
      total++;
      if (nd != 1) begin
        bad++;
        $display("FAIL random_done_count job=%0d m=%0d got=%0d exp=1", j, m, nd);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    num_rows = '0;
    test_reset();
    test_basic();
    test_stall();
    test_m_zero();
    test_start_ignored();
    test_reset_mid();
    test_max_rows();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
